tms34020_mc_arb: RTL and testbench
==================================

TMS34020_MC_ARB -- requirements
Module: tms34020_mc_arb

Interface
REQ-001 Parameter NCH, default 4, number of requester channels (2..8); channel 0 is highest priority.
REQ-002 Parameter DW, default 32, data-bus width in bits (multiple of 8); byte lanes NB = DW/8.
REQ-003 Parameter TO_CYC, default 255, number of DBUS_RDY wait cycles before a transfer is aborted (1..1023).
REQ-004 Port CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port RST  in  1  synchronous, active-high reset.
REQ-006 Port EN  in  1  clock enable; when low, all state and outputs hold.
REQ-007 Ports CH_REQ/CH_WE  in  NCH each  per-channel request and write (1) / read (0) select.
REQ-008 Ports CH_ADDR  in  NCH*32, CH_WDATA  in  NCH*DW, CH_BE  in  NCH*NB, CH_CODE  in  NCH*4: per-channel address, write data, byte enables and cycle code.
REQ-009 Ports CH_ACK  out  NCH, CH_ERR  out  1, CH_RDATA  out  DW: completion pulse, timeout flag, read data.
REQ-010 Ports DBUS_A  out  32, DBUS_DO  out  DW, DBUS_BE  out  NB, DBUS_CODE  out  4, DBUS_RAS/DBUS_RD/DBUS_WE  out  1 each: memory bus outputs.
REQ-011 Ports DBUS_DI  in  DW, DBUS_RDY  in  1: memory read data and ready.

Function
REQ-012 States IDLE, ADDR, CMD, WAIT, DONE; plus MERGE when the RMW feature (REQ-025) is compiled in.
REQ-013 IDLE: if any CH_REQ is high, the lowest-index requesting channel is granted and its ADDR/WDATA/BE/CODE/WE are latched; next state ADDR.
REQ-014 IDLE with no request: DBUS_RAS=0, DBUS_RD=0, DBUS_WE=0 and DBUS_CODE=4'b1111.
REQ-015 ADDR: DBUS_A, DBUS_BE and DBUS_CODE are driven from the latched values and DBUS_RAS=1; next state CMD.
REQ-016 CMD: DBUS_RD=1 for a read or DBUS_WE=1 with DBUS_DO=latched data for a write; the timeout counter is cleared; next state WAIT.
REQ-017 WAIT: DBUS_RDY is sampled each cycle and the counter increments. On RDY=1 a read captures DBUS_DI into CH_RDATA; next state DONE.
REQ-018 WAIT: when the counter reaches TO_CYC without RDY, CH_ERR=1 and CH_RDATA is held; next state DONE.
REQ-019 DONE: CH_ACK[grant] is high for exactly one cycle and DBUS_RAS/RD/WE=0; next state IDLE.
REQ-020 Latency: a request in IDLE at cycle 0 with RDY already high gives RAS at cycle 1, RD/WE at cycle 2, ACK at cycle 4.
REQ-021 A requester drops CH_REQ on the edge that ends its ACK cycle; the request is re-arbitrated in the following IDLE cycle.
REQ-022 A granted transfer always completes, even if its CH_REQ drops early; a CH_REQ that rises mid-transfer waits for IDLE.
REQ-023 When several requests are pending at IDLE, only priority decides the grant; no fairness is provided (fixed priority).
REQ-024 CH_ERR is cleared at the next grant; CH_RDATA is unchanged by writes.

Configuration
REQ-025 Macro TMS34020_MC_RMW_EN: when defined, a write whose BE is not all ones runs as a read (ADDR,CMD,WAIT), then MERGE, then a second CMD/WAIT that writes merged data with BE all ones.
REQ-026 In MERGE, lanes whose BE bit is set take CH_WDATA and all other lanes take the read DBUS_DI; RAS stays high across the whole sequence; ACK is given once, at the final DONE.
REQ-027 When the macro is not defined, partial writes are issued directly with DBUS_BE=CH_BE, and the MERGE state and merge logic are absent.
REQ-028 With the macro defined, a timeout during the read phase aborts the write: no WE is issued and CH_ERR=1.

Reset
REQ-029 While RST=1 at a clock edge: state=IDLE, CH_ACK=0, CH_ERR=0, CH_RDATA=0, DBUS_A=0, DBUS_DO=0, DBUS_BE=0, DBUS_RAS/RD/WE=0, DBUS_CODE=4'b1111, counter=0.
REQ-030 RST asserted mid-transfer (any state) abandons the transfer at the next edge, gives no ACK, and deasserts the bus the same cycle.
REQ-031 RST overrides EN.

Verification
REQ-032 Ch2 reads 0x00001000 and RDY is held high -> RAS at cycle 1, RD at cycle 2, CH_RDATA=DBUS_DI, CH_ACK=4'b0100 at cycle 4.
REQ-033 Ch1 and ch3 request together -> ch1 is served first, ch3 is granted in the IDLE cycle after ch1's ACK, and no cycle has two ACK bits set.
REQ-034 DBUS_RDY held low with TO_CYC=4 -> CH_ERR=1 and a single ACK pulse, with the bus idle after DONE.
REQ-035 TMS34020_MC_RMW_EN defined, ch0 writes 0xAABBCCDD with BE=4'b0101 over memory word 0x11223344 -> final write of 0x11BB33DD with BE=4'b1111 and RAS continuously high.
REQ-036 Same stimulus with the macro not defined -> a single write cycle with DBUS_BE=4'b0101 and DBUS_DO=0xAABBCCDD.
REQ-037 RST pulsed during WAIT -> next cycle all bus strobes are 0 and no ACK is given; a fresh request is then served normally.

Source files
------------

// File: rtl/tms34020_mc_arb_if.sv
// Request-channel and memory-bus signal bundle for the TMS34020 memory-cycle arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface tms34020_mc_arb_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 32
);
  localparam int unsigned NB = DW / 8;

  logic [NCH-1:0]    CH_REQ;
  logic [NCH-1:0]    CH_WE;
  logic [NCH*32-1:0] CH_ADDR;
  logic [NCH*DW-1:0] CH_WDATA;
  logic [NCH*NB-1:0] CH_BE;
  logic [NCH*4-1:0]  CH_CODE;
  logic [NCH-1:0]    CH_ACK;
  logic              CH_ERR;
  logic [DW-1:0]     CH_RDATA;

  logic [31:0]       DBUS_A;
  logic [DW-1:0]     DBUS_DO;
  logic [NB-1:0]     DBUS_BE;
  logic [3:0]        DBUS_CODE;
  logic              DBUS_RAS;
  logic              DBUS_RD;
  logic              DBUS_WE;
  logic [DW-1:0]     DBUS_DI;
  logic              DBUS_RDY;

  modport slave (
    input  CH_REQ, CH_WE, CH_ADDR, CH_WDATA, CH_BE, CH_CODE, DBUS_DI, DBUS_RDY,
    output CH_ACK, CH_ERR, CH_RDATA,
    output DBUS_A, DBUS_DO, DBUS_BE, DBUS_CODE, DBUS_RAS, DBUS_RD, DBUS_WE
  );

  modport master (
    output CH_REQ, CH_WE, CH_ADDR, CH_WDATA, CH_BE, CH_CODE, DBUS_DI, DBUS_RDY,
    input  CH_ACK, CH_ERR, CH_RDATA,
    input  DBUS_A, DBUS_DO, DBUS_BE, DBUS_CODE, DBUS_RAS, DBUS_RD, DBUS_WE
  );
endinterface

// File: rtl/tms34020_mc_arb.sv
// Fixed-priority memory-cycle arbiter with DBUS_RDY timeout (channel 0 highest priority).
// Define TMS34020_MC_RMW_EN to run partial-byte writes as read-merge-write.
module tms34020_mc_arb #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned DW     = 32,
  parameter int unsigned TO_CYC = 255
) (
  input logic              CLK,
  input logic              RST,
  input logic              EN,
  tms34020_mc_arb_if.slave bus
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned CW = $clog2(TO_CYC + 1);
  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StCmd,
    StWait,
    StDone
`ifdef TMS34020_MC_RMW_EN
    , StMerge
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [DW-1:0]  do_q, do_d;
  logic [NB-1:0]  be_q, be_d;
  logic [3:0]     code_q, code_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           rd_op;
`ifdef TMS34020_MC_RMW_EN
  logic           rmw_q, rmw_d;    // write is still in its read phase
  logic [DW-1:0]  rbuf_q, rbuf_d;
`endif

  logic req_any;
  int   req_idx;

  always_comb begin
    req_any = |bus.CH_REQ;
    req_idx = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.CH_REQ[i]) req_idx = i;
    end
  end

`ifdef TMS34020_MC_RMW_EN
  assign rd_op = !we_q || rmw_q;
`else
  assign rd_op = !we_q;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    do_d    = do_q;
    be_d    = be_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef TMS34020_MC_RMW_EN
    rmw_d   = rmw_q;
    rbuf_d  = rbuf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          grant_d = GW'(req_idx);
          we_d    = bus.CH_WE[req_idx];
          addr_d  = bus.CH_ADDR[32*req_idx +: 32];
          do_d    = bus.CH_WDATA[DW*req_idx +: DW];
          be_d    = bus.CH_BE[NB*req_idx +: NB];
          code_d  = bus.CH_CODE[4*req_idx +: 4];
          err_d   = 1'b0;
`ifdef TMS34020_MC_RMW_EN
          rmw_d   = bus.CH_WE[req_idx] && (bus.CH_BE[NB*req_idx +: NB] != {NB{1'b1}});
`endif
          state_d = StAddr;
        end
      end
      StAddr: state_d = StCmd;
      StCmd: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.DBUS_RDY) begin
`ifdef TMS34020_MC_RMW_EN
          if (rmw_q) begin
            rbuf_d  = bus.DBUS_DI;
            state_d = StMerge;
          end else begin
            if (!we_q) rdata_d = bus.DBUS_DI;
            state_d = StDone;
          end
`else
          if (!we_q) rdata_d = bus.DBUS_DI;
          state_d = StDone;
`endif
        end else if (cnt_q + 1'b1 == CW'(TO_CYC)) begin
          // Timeout: abandon the transfer, flag it and keep the old read data.
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
`ifdef TMS34020_MC_RMW_EN
      StMerge: begin
        for (int b = 0; b < NB; b++) begin
          do_d[8*b +: 8] = be_q[b] ? do_q[8*b +: 8] : rbuf_q[8*b +: 8];
        end
        be_d    = {NB{1'b1}};
        rmw_d   = 1'b0;
        state_d = StCmd;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      do_q    <= '0;
      be_q    <= '0;
      code_q  <= 4'b1111;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef TMS34020_MC_RMW_EN
      rmw_q   <= 1'b0;
      rbuf_q  <= '0;
`endif
    end else if (EN) begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      do_q    <= do_d;
      be_q    <= be_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef TMS34020_MC_RMW_EN
      rmw_q   <= rmw_d;
      rbuf_q  <= rbuf_d;
`endif
    end
  end

  // Strobes decode from state so reset deasserts the bus in the very next cycle.
  always_comb begin
    bus.DBUS_RAS  = (state_q == StAddr) || (state_q == StCmd) || (state_q == StWait)
`ifdef TMS34020_MC_RMW_EN
                    || (state_q == StMerge)
`endif
                    ;
    bus.DBUS_RD   = ((state_q == StCmd) || (state_q == StWait)) && rd_op;
    bus.DBUS_WE   = ((state_q == StCmd) || (state_q == StWait)) && !rd_op;
    bus.DBUS_CODE = ((state_q == StIdle) || (state_q == StDone)) ? 4'b1111 : code_q;
    bus.DBUS_A    = addr_q;
    bus.DBUS_DO   = do_q;
    bus.DBUS_BE   = be_q;
    bus.CH_ACK    = (state_q == StDone) ? (NCH'(1) << grant_q) : '0;
    bus.CH_ERR    = err_q;
    bus.CH_RDATA  = rdata_q;
  end
endmodule

// File: tb/tb_tms34020_mc_arb.sv
// Self-checking bench for tms34020_mc_arb: directed scenarios plus randomized multi-channel
// rounds checked against a transaction-level timing/data model.
`timescale 1ns/1ps
module tb_tms34020_mc_arb;
  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned NB  = DW / 8;
  localparam int unsigned TO  = 4;

  logic CLK = 1'b0;
  logic RST;
  logic EN;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [DW-1:0] m_rdata;

  tms34020_mc_arb_if #(.NCH(NCH), .DW(DW)) bus ();
  tms34020_mc_arb #(.NCH(NCH), .DW(DW), .TO_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .bus(bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'h1122_3344;
    return {a[15:0], ~a[31:16]} ^ 32'h3C3C_0F0F;
  endfunction

  // Memory answers DBUS_RDY after addr[2:0] wait cycles; 4..7 never answer in time.
  function automatic int dly_of(input logic [31:0] a);
    return int'(a[2:0]);
  endfunction

  int str_cnt = 0;
  logic ras_p = 1'b0, we_p = 1'b0;
  logic [31:0]   aq[$];
  logic [3:0]    cq[$];
  logic [31:0]   wa[$];
  logic [DW-1:0] wd[$];
  logic [NB-1:0] wb[$];

  always @(negedge CLK) begin
    if (bus.DBUS_RD || bus.DBUS_WE) str_cnt = str_cnt + 1;
    else str_cnt = 0;
    bus.DBUS_RDY = (str_cnt >= dly_of(bus.DBUS_A) + 2);
    bus.DBUS_DI  = mem_of(bus.DBUS_A);
    if (bus.DBUS_RAS && !ras_p) begin
      aq.push_back(bus.DBUS_A);
      cq.push_back(bus.DBUS_CODE);
    end
    if (bus.DBUS_WE && !we_p) begin
      wa.push_back(bus.DBUS_A);
      wd.push_back(bus.DBUS_DO);
      wb.push_back(bus.DBUS_BE);
    end
    ras_p = bus.DBUS_RAS;
    we_p  = bus.DBUS_WE;
  end

  task automatic set_ch(input int ch, input logic we, input logic [31:0] a,
                        input logic [DW-1:0] d, input logic [NB-1:0] be, input logic [3:0] code);
    bus.CH_WE[ch]               = we;
    bus.CH_ADDR[32*ch +: 32]    = a;
    bus.CH_WDATA[DW*ch +: DW]   = d;
    bus.CH_BE[NB*ch +: NB]      = be;
    bus.CH_CODE[4*ch +: 4]      = code;
  endtask

  task automatic clear_q();
    aq.delete(); cq.delete(); wa.delete(); wd.delete(); wb.delete();
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b1;
    bus.CH_REQ = '1;
    repeat (3) @(negedge CLK);
    n_chk++; if (bus.CH_ACK !== '0) $display("FAIL reset_ack got %b want 0", bus.CH_ACK); else n_pass++;
    n_chk++; if (bus.CH_ERR !== 1'b0 || bus.CH_RDATA !== '0)
      $display("FAIL reset_ch got err=%b rdata=%h want 0/0", bus.CH_ERR, bus.CH_RDATA); else n_pass++;
    n_chk++; if (bus.DBUS_A !== '0 || bus.DBUS_DO !== '0 || bus.DBUS_BE !== '0)
      $display("FAIL reset_dbus got a=%h do=%h be=%b want 0", bus.DBUS_A, bus.DBUS_DO, bus.DBUS_BE);
    else n_pass++;
    n_chk++; if ({bus.DBUS_RAS, bus.DBUS_RD, bus.DBUS_WE} !== 3'b000 || bus.DBUS_CODE !== 4'hF)
      $display("FAIL reset_strobes got %b code=%h want 000/f",
               {bus.DBUS_RAS, bus.DBUS_RD, bus.DBUS_WE}, bus.DBUS_CODE);
    else n_pass++;
    EN = 1'b0;
    @(negedge CLK);
    n_chk++; if (bus.DBUS_RAS !== 1'b0) $display("FAIL reset_over_en got ras=%b want 0", bus.DBUS_RAS);
    else n_pass++;
    bus.CH_REQ = '0; EN = 1'b1; RST = 1'b0;
    @(negedge CLK);
    n_chk++; if (bus.DBUS_CODE !== 4'hF || bus.DBUS_RAS !== 1'b0)
      $display("FAIL idle_bus got code=%h ras=%b want f/0", bus.DBUS_CODE, bus.DBUS_RAS);
    else n_pass++;
    m_rdata = '0;
  endtask

  task automatic test_read_latency();
    set_ch(2, 1'b0, 32'h0000_1000, '0, '1, 4'h3);
    bus.CH_REQ = 4'b0100;
    @(negedge CLK);
    n_chk++; if (bus.DBUS_RAS !== 1'b1 || bus.DBUS_RD !== 1'b0 || bus.DBUS_A !== 32'h1000)
      $display("FAIL lat_c1 got ras=%b rd=%b a=%h want 1/0/1000", bus.DBUS_RAS, bus.DBUS_RD, bus.DBUS_A);
    else n_pass++;
    @(negedge CLK);
    n_chk++; if (bus.DBUS_RD !== 1'b1 || bus.DBUS_WE !== 1'b0)
      $display("FAIL lat_c2 got rd=%b we=%b want 1/0", bus.DBUS_RD, bus.DBUS_WE); else n_pass++;
    @(negedge CLK);
    n_chk++; if (bus.CH_ACK !== '0) $display("FAIL lat_c3 got ack=%b want 0", bus.CH_ACK); else n_pass++;
    @(negedge CLK);
    n_chk++; if (bus.CH_ACK !== 4'b0100) $display("FAIL lat_ack got %b want 0100", bus.CH_ACK);
    else n_pass++;
    m_rdata = mem_of(32'h1000);
    n_chk++; if (bus.CH_RDATA !== m_rdata || bus.CH_ERR !== 1'b0)
      $display("FAIL lat_rdata got %h err=%b want %h/0", bus.CH_RDATA, bus.CH_ERR, m_rdata);
    else n_pass++;
    bus.CH_REQ = '0;
    @(negedge CLK);
    n_chk++; if (bus.CH_ACK !== '0 || bus.DBUS_RAS !== 1'b0)
      $display("FAIL lat_c5 got ack=%b ras=%b want 0/0", bus.CH_ACK, bus.DBUS_RAS); else n_pass++;
  endtask

  task automatic test_priority();
    int t1 = -1, t3 = -1, dual = 0;
    logic [DW-1:0] rd3 = '0;
    @(negedge CLK);
    set_ch(1, 1'b0, 32'h0000_3000, '0, '1, 4'h1);
    set_ch(3, 1'b0, 32'h0000_4008, '0, '1, 4'h2);
    bus.CH_REQ = 4'b1010;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      if ($countones(bus.CH_ACK) > 1) dual++;
      if (bus.CH_ACK[1]) begin t1 = c; bus.CH_REQ[1] = 1'b0; end
      if (bus.CH_ACK[3]) begin t3 = c; rd3 = bus.CH_RDATA; bus.CH_REQ[3] = 1'b0; end
    end
    n_chk++; if (t1 != 4) $display("FAIL prio_ch1_ack got cycle %0d want 4", t1); else n_pass++;
    n_chk++; if (t3 != 9) $display("FAIL prio_ch3_ack got cycle %0d want 9", t3); else n_pass++;
    n_chk++; if (dual != 0) $display("FAIL prio_dual_ack got %0d cycles want 0", dual); else n_pass++;
    m_rdata = mem_of(32'h4008);
    n_chk++; if (rd3 !== m_rdata) $display("FAIL prio_rdata got %h want %h", rd3, m_rdata);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int acks = 0, t_ack = -1, idle_after = 0;
    logic err_at = 1'b0, prev_ack = 1'b0;
    logic [DW-1:0] rd_at = '0;
    set_ch(0, 1'b0, 32'h0000_5007, '0, '1, 4'h4);
    bus.CH_REQ = 4'b0001;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (prev_ack) idle_after = ({bus.DBUS_RAS, bus.DBUS_RD, bus.DBUS_WE} == 3'b000) ? 1 : 0;
      prev_ack = (bus.CH_ACK != '0);
      if (bus.CH_ACK != '0) begin
        acks++; t_ack = c; err_at = bus.CH_ERR; rd_at = bus.CH_RDATA; bus.CH_REQ = '0;
      end
    end
    n_chk++; if (acks != 1) $display("FAIL to_ack_count got %0d want 1", acks); else n_pass++;
    n_chk++; if (t_ack != 3 + TO) $display("FAIL to_ack_cycle got %0d want %0d", t_ack, 3 + TO);
    else n_pass++;
    n_chk++; if (err_at !== 1'b1) $display("FAIL to_err got %b want 1", err_at); else n_pass++;
    n_chk++; if (rd_at !== m_rdata) $display("FAIL to_rdata_held got %h want %h", rd_at, m_rdata);
    else n_pass++;
    n_chk++; if (idle_after != 1) $display("FAIL to_bus_idle got %0d want 1", idle_after); else n_pass++;
  endtask

  task automatic test_partial_write();
    int t_ack = -1, gaps = 0;
    logic seen_ras = 1'b0;
    logic [DW-1:0] rd_at = '0;
`ifdef TMS34020_MC_RMW_EN
    logic [DW-1:0] exp_d = 32'h11BB_33DD;
    logic [NB-1:0] exp_b = 4'b1111;
    int exp_t = 7;
`else
    logic [DW-1:0] exp_d = 32'hAABB_CCDD;
    logic [NB-1:0] exp_b = 4'b0101;
    int exp_t = 4;
`endif
    clear_q();
    set_ch(0, 1'b1, 32'h0000_2000, 32'hAABB_CCDD, 4'b0101, 4'h5);
    bus.CH_REQ = 4'b0001;
    for (int c = 1; c <= 20 && t_ack < 0; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        n_chk++; if (bus.CH_ERR !== 1'b0) $display("FAIL err_clear got %b want 0", bus.CH_ERR);
        else n_pass++;
      end
      if (bus.CH_ACK != '0) begin
        t_ack = c; rd_at = bus.CH_RDATA; bus.CH_REQ = '0;
      end else if (bus.DBUS_RAS) seen_ras = 1'b1;
      else if (seen_ras) gaps++;
    end
    n_chk++; if (t_ack != exp_t) $display("FAIL pw_ack got cycle %0d want %0d", t_ack, exp_t);
    else n_pass++;
    n_chk++; if (gaps != 0) $display("FAIL pw_ras_gap got %0d want 0", gaps); else n_pass++;
    n_chk++; if (wd.size() != 1) $display("FAIL pw_we_count got %0d want 1", wd.size());
    else begin
      n_pass++;
      n_chk++; if (wd[0] !== exp_d || wb[0] !== exp_b || wa[0] !== 32'h2000)
        $display("FAIL pw_data got %h be=%b a=%h want %h/%b/2000", wd[0], wb[0], wa[0], exp_d, exp_b);
      else n_pass++;
    end
    n_chk++; if (rd_at !== m_rdata) $display("FAIL pw_rdata_held got %h want %h", rd_at, m_rdata);
    else n_pass++;
    @(negedge CLK);
  endtask

  task automatic test_enable();
    int t_ack = -1, hold_bad = 0;
    set_ch(3, 1'b0, 32'h0000_6000, '0, '1, 4'h6);
    bus.CH_REQ = 4'b1000;
    @(negedge CLK);
    EN = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge CLK);
      if (bus.DBUS_RAS !== 1'b1 || bus.DBUS_RD !== 1'b0) hold_bad++;
    end
    EN = 1'b1;
    for (int c = 5; c <= 15 && t_ack < 0; c++) begin
      @(negedge CLK);
      if (bus.CH_ACK != '0) begin
        t_ack = c; bus.CH_REQ = '0;
        m_rdata = mem_of(32'h6000);
        n_chk++; if (bus.CH_RDATA !== m_rdata)
          $display("FAIL en_rdata got %h want %h", bus.CH_RDATA, m_rdata); else n_pass++;
      end
    end
    n_chk++; if (hold_bad != 0) $display("FAIL en_hold got %0d bad cycles want 0", hold_bad);
    else n_pass++;
    n_chk++; if (t_ack != 7) $display("FAIL en_ack got cycle %0d want 7", t_ack); else n_pass++;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int acks = 0, t_ack = -1;
    set_ch(1, 1'b0, 32'h0000_7007, '0, '1, 4'h7);
    bus.CH_REQ = 4'b0010;
    repeat (4) @(negedge CLK);
    RST = 1'b1; bus.CH_REQ = '0;
    @(negedge CLK);
    RST = 1'b0;
    n_chk++; if ({bus.DBUS_RAS, bus.DBUS_RD, bus.DBUS_WE} !== 3'b000 || bus.CH_ACK !== '0)
      $display("FAIL rstmid_bus got %b ack=%b want 000/0",
               {bus.DBUS_RAS, bus.DBUS_RD, bus.DBUS_WE}, bus.CH_ACK);
    else n_pass++;
    m_rdata = '0;
    n_chk++; if (bus.CH_RDATA !== m_rdata) $display("FAIL rstmid_rdata got %h want 0", bus.CH_RDATA);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.CH_ACK != '0) acks++;
    end
    n_chk++; if (acks != 0) $display("FAIL rstmid_noack got %0d want 0", acks); else n_pass++;
    set_ch(1, 1'b0, 32'h0000_7000, '0, '1, 4'h7);
    bus.CH_REQ = 4'b0010;
    for (int c = 1; c <= 15 && t_ack < 0; c++) begin
      @(negedge CLK);
      if (bus.CH_ACK == 4'b0010) begin t_ack = c; bus.CH_REQ = '0; end
    end
    m_rdata = mem_of(32'h7000);
    n_chk++; if (t_ack != 4 || bus.CH_RDATA !== m_rdata)
      $display("FAIL rstmid_fresh got cycle %0d rdata %h want 4/%h", t_ack, bus.CH_RDATA, m_rdata);
    else n_pass++;
    @(negedge CLK);
  endtask

  task automatic test_random();
    logic [NCH-1:0] mask, oh;
    logic           we[NCH];
    logic [31:0]    ad[NCH];
    logic [DW-1:0]  da[NCH];
    logic [NB-1:0]  be[NCH];
    logic [3:0]     cd[NCH];
    int             t_exp[NCH];
    logic           e_exp[NCH];
    int             ord[$];
    int             t, w, k, rel, ch;
    for (int r = 0; r < 30; r++) begin
      mask = NCH'($urandom_range(1, (1 << NCH) - 1));
      ord.delete();
      t = 0;
      // Model: all requests appear together; service is ascending index, back to back.
      for (int i = 0; i < NCH; i++) begin
        we[i] = 1'($urandom);
        ad[i] = $urandom;
        da[i] = $urandom;
`ifdef TMS34020_MC_RMW_EN
        be[i] = '1;
`else
        be[i] = NB'($urandom);
`endif
        cd[i] = 4'($urandom);
        set_ch(i, we[i], ad[i], da[i], be[i], cd[i]);
        if (mask[i]) begin
          e_exp[i] = dly_of(ad[i]) >= TO;
          w = e_exp[i] ? TO : dly_of(ad[i]) + 1;
          t_exp[i] = t + 3 + w;
          t = t_exp[i] + 1;
          ord.push_back(i);
        end
      end
      clear_q();
      bus.CH_REQ = mask;
      k = 0; rel = 0;
      while (k < ord.size() && rel < 200) begin
        @(negedge CLK);
        rel++;
        if (bus.CH_ACK != '0) begin
          ch = ord[k];
          oh = '0; oh[ch] = 1'b1;
          n_chk++; if (bus.CH_ACK !== oh || rel != t_exp[ch])
            $display("FAIL rnd_ack r%0d got %b@%0d want %b@%0d", r, bus.CH_ACK, rel, oh, t_exp[ch]);
          else n_pass++;
          n_chk++; if (bus.CH_ERR !== e_exp[ch])
            $display("FAIL rnd_err r%0d ch%0d got %b want %b", r, ch, bus.CH_ERR, e_exp[ch]);
          else n_pass++;
          if (!we[ch] && !e_exp[ch]) m_rdata = mem_of(ad[ch]);
          n_chk++; if (bus.CH_RDATA !== m_rdata)
            $display("FAIL rnd_rdata r%0d ch%0d got %h want %h", r, ch, bus.CH_RDATA, m_rdata);
          else n_pass++;
          n_chk++; if (aq.size() == 0 || aq[0] !== ad[ch] || cq[0] !== cd[ch])
            $display("FAIL rnd_addr r%0d ch%0d got %0d entries want a=%h code=%h",
                     r, ch, aq.size(), ad[ch], cd[ch]);
          else n_pass++;
          if (aq.size() != 0) begin void'(aq.pop_front()); void'(cq.pop_front()); end
          if (we[ch]) begin
            n_chk++; if (wd.size() == 0 || wd[0] !== da[ch] || wb[0] !== be[ch] || wa[0] !== ad[ch])
              $display("FAIL rnd_write r%0d ch%0d got %0d entries want %h/%b", r, ch, wd.size(),
                       da[ch], be[ch]);
            else n_pass++;
            if (wd.size() != 0) begin
              void'(wd.pop_front()); void'(wb.pop_front()); void'(wa.pop_front());
            end
          end
          bus.CH_REQ[ch] = 1'b0;
          k++;
        end
      end
      n_chk++; if (k != ord.size()) $display("FAIL rnd_done r%0d got %0d acks want %0d", r, k, ord.size());
      else n_pass++;
      bus.CH_REQ = '0;
      @(negedge CLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; EN = 1'b1;
    bus.CH_REQ = '0; bus.CH_WE = '0; bus.CH_ADDR = '0;
    bus.CH_WDATA = '0; bus.CH_BE = '0; bus.CH_CODE = '0;
    m_rdata = '0;
    test_reset();
    test_read_latency();
    test_priority();
    test_timeout();
    test_partial_write();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
